tbb: RTL and testbench

Task batch buffer: receive side of the batch interface whose send side is the result batch buffer. On FillStart it requests every line of one task batch from the host read path and writes the out-of-order responses into a simple-dual-port BRAM. Once all lines have arrived it presents the batch to a PE array, which reads it by address and releases it with BatchDone. One instance sits in front of each PE array.

---
 rtl/tbb_if.sv | 29 ++
 rtl/tbb.sv | 90 +++++++++
 tb/tb_tbb.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tbb_if.sv
// rtl/tbb_if.sv - task batch buffer bus: host fetch, response and PE read signals
interface tbb_if #(
  parameter int TBB_ADDR_WIDTH = 4,
  parameter int TBB_DATA_WIDTH = 512
);
  logic                      FillStart;
  logic                      ReqValid;
  logic [TBB_ADDR_WIDTH-1:0] ReqLineIdx;
  logic                      ReqAck;
  logic                      RspValid;
  logic [TBB_ADDR_WIDTH-1:0] RspLineIdx;
  logic [TBB_DATA_WIDTH-1:0] RspData;
  logic                      Full;
  logic                      Empty;
  logic [TBB_ADDR_WIDTH:0]   LinesRcvd;
  logic [TBB_ADDR_WIDTH-1:0] RdAddr;
  logic [TBB_DATA_WIDTH-1:0] RdDout;
  logic                      BatchDone;

  modport slave (
    input  FillStart, ReqAck, RspValid, RspLineIdx, RspData, RdAddr, BatchDone,
    output ReqValid, ReqLineIdx, Full, Empty, LinesRcvd, RdDout
  );

  modport master (
    output FillStart, ReqAck, RspValid, RspLineIdx, RspData, RdAddr, BatchDone,
    input  ReqValid, ReqLineIdx, Full, Empty, LinesRcvd, RdDout
  );
endinterface

// File: rtl/tbb.sv
// rtl/tbb.sv - task batch buffer: fetches one batch of lines into BRAM and serves it to a PE array
module tbb #(
  parameter int TBB_ADDR_WIDTH = 4,
  parameter int TBB_DATA_WIDTH = 512
) (
  input  logic clk,
  input  logic reset_n,
  tbb_if.slave bus
);
  localparam int NUM_LINES = 2 ** TBB_ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  localparam logic [TBB_ADDR_WIDTH-1:0] LAST_IDX  = {TBB_ADDR_WIDTH{1'b1}};
  localparam logic [TBB_ADDR_WIDTH:0]   ALL_LINES = {1'b1, {TBB_ADDR_WIDTH{1'b0}}};

  logic [1:0]                state;
  logic [TBB_ADDR_WIDTH-1:0] req_cnt;
  logic [TBB_ADDR_WIDTH:0]   lines_rcvd;
  logic                      rsp_accept;
  logic [TBB_DATA_WIDTH-1:0] mem [NUM_LINES];
  logic [TBB_DATA_WIDTH-1:0] rd_q;

  // Responses only land while a fetch is in flight; stale ones after reset are dropped.
  assign rsp_accept = reset_n && bus.RspValid && ((state == ST_REQ) || (state == ST_WAIT));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      req_cnt    <= '0;
      lines_rcvd <= '0;
    end else begin
      if (rsp_accept) begin
        lines_rcvd <= lines_rcvd + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.FillStart) begin
            state      <= ST_REQ;
            req_cnt    <= '0;
            lines_rcvd <= '0;
          end
        end
        ST_REQ: begin
          if (bus.ReqAck) begin
            req_cnt <= req_cnt + 1'b1;
            if (req_cnt == LAST_IDX) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (lines_rcvd == ALL_LINES) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (bus.BatchDone) begin
            if (bus.FillStart) begin
              state      <= ST_REQ;
              req_cnt    <= '0;
              lines_rcvd <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Simple-dual-port BRAM: read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (rsp_accept) begin
      mem[bus.RspLineIdx] <= bus.RspData;
    end
    rd_q <= mem[bus.RdAddr];
  end

  assign bus.ReqValid   = (state == ST_REQ);
  assign bus.ReqLineIdx = req_cnt;
  assign bus.Full       = (state == ST_READY);
  assign bus.Empty      = (state == ST_IDLE);
  assign bus.LinesRcvd  = lines_rcvd;
  assign bus.RdDout     = rd_q;
endmodule

// File: tb/tb_tbb.sv
// tb/tb_tbb.sv - directed scoreboard bench for the task batch buffer
module tb_tbb;
  localparam int AW = 2;
  localparam int DW = 32;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  logic [DW-1:0] model [4];
  logic [DW-1:0] rd_q [$];

  tbb_if #(.TBB_ADDR_WIDTH(AW), .TBB_DATA_WIDTH(DW)) bus ();

  tbb #(.TBB_ADDR_WIDTH(AW), .TBB_DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp(input int idx, input logic [DW-1:0] data);
    bus.RspValid   = 1'b1;
    bus.RspLineIdx = AW'(idx);
    bus.RspData    = data;
  endtask

  task automatic read_line(input int addr);
    bus.RdAddr = AW'(addr);
    rd_q.push_back(model[addr]);
    cycle();
    check($sformatf("rd_addr%0d", addr), bus.RdDout, rd_q.pop_front());
  endtask

  initial begin
    int ord[4];
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.FillStart = 1'b0;
    bus.ReqAck = 1'b0;
    bus.RspValid = 1'b0;
    bus.RspLineIdx = '0;
    bus.RspData = '0;
    bus.RdAddr = '0;
    bus.BatchDone = 1'b0;
    cycle();
    cycle();
    check("rst_req_valid", bus.ReqValid, 0);
    check("rst_req_idx", bus.ReqLineIdx, 0);
    check("rst_full", bus.Full, 0);
    check("rst_empty", bus.Empty, 1);
    check("rst_lines", bus.LinesRcvd, 0);
    reset_n = 1'b1;
    cycle();

    // Basic in-order fill
    bus.FillStart = 1'b1;
    cycle();
    bus.FillStart = 1'b0;
    check("t1_req_valid", bus.ReqValid, 1);
    check("t1_idx0", bus.ReqLineIdx, 0);
    bus.ReqAck = 1'b1;
    cycle();
    check("t1_idx1", bus.ReqLineIdx, 1);
    for (int i = 0; i < 3; i++) begin
      drive_rsp(i, 32'hA0 + i);
      model[i] = 32'hA0 + i;
      cycle();
      if (i < 2) check($sformatf("t1_idx%0d", i + 2), bus.ReqLineIdx, i + 2);
    end
    check("t1_wait_req_valid", bus.ReqValid, 0);
    bus.ReqAck = 1'b0;
    drive_rsp(3, 32'hA3);
    model[3] = 32'hA3;
    cycle();
    bus.RspValid = 1'b0;
    check("t1_lines4", bus.LinesRcvd, 4);
    check("t1_full_not_yet", bus.Full, 0);
    cycle();
    check("t1_full", bus.Full, 1);
    read_line(2);

    // Release alone
    bus.BatchDone = 1'b1;
    cycle();
    bus.BatchDone = 1'b0;
    check("t3_empty", bus.Empty, 1);
    check("t3_full_clear", bus.Full, 0);

    // Out-of-order responses with backpressure
    bus.FillStart = 1'b1;
    cycle();
    bus.FillStart = 1'b0;
    check("t2_lines_clear", bus.LinesRcvd, 0);
    for (int i = 0; i < 4; i++) begin
      bus.ReqAck = 1'b0;
      cycle();
      check($sformatf("t2_hold%0d", i), bus.ReqLineIdx, i);
      bus.ReqAck = 1'b1;
      cycle();
    end
    bus.ReqAck = 1'b0;
    check("t2_wait", bus.ReqValid, 0);
    ord = '{3, 0, 2, 1};
    for (int k = 0; k < 4; k++) begin
      drive_rsp(ord[k], 32'hB0 + ord[k]);
      model[ord[k]] = 32'hB0 + ord[k];
      cycle();
      check($sformatf("t2_lines%0d", k + 1), bus.LinesRcvd, k + 1);
      check($sformatf("t2_not_full%0d", k), bus.Full, 0);
    end
    bus.RspValid = 1'b0;
    cycle();
    check("t2_full", bus.Full, 1);
    for (int a = 0; a < 4; a++) read_line(a);

    // FillStart alone in READY is ignored, then back-to-back
    bus.FillStart = 1'b1;
    cycle();
    check("t3_fill_ignored", bus.Full, 1);
    bus.BatchDone = 1'b1;
    cycle();
    bus.BatchDone = 1'b0;
    bus.FillStart = 1'b0;
    check("t3_b2b_req_valid", bus.ReqValid, 1);
    check("t3_b2b_idx", bus.ReqLineIdx, 0);
    check("t3_b2b_full", bus.Full, 0);
    check("t3_b2b_lines", bus.LinesRcvd, 0);

    // BatchDone in REQ is ignored
    bus.BatchDone = 1'b1;
    cycle();
    bus.BatchDone = 1'b0;
    check("t4_bd_in_req", bus.ReqValid, 1);
    check("t4_bd_empty", bus.Empty, 0);

    // Reset mid-fill after two acks, then stale responses
    bus.ReqAck = 1'b1;
    cycle();
    cycle();
    bus.ReqAck = 1'b0;
    check("t5_idx2", bus.ReqLineIdx, 2);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check("t5_empty", bus.Empty, 1);
    check("t5_req_valid", bus.ReqValid, 0);
    check("t5_lines", bus.LinesRcvd, 0);
    drive_rsp(0, 32'hDEAD);
    cycle();
    drive_rsp(1, 32'hBEEF);
    cycle();
    bus.RspValid = 1'b0;
    check("t5_stale_lines", bus.LinesRcvd, 0);
    check("t5_stale_empty", bus.Empty, 1);

    // Response in IDLE is ignored and must not reach the BRAM
    drive_rsp(1, 32'hFF);
    cycle();
    bus.RspValid = 1'b0;
    check("t4_idle_lines", bus.LinesRcvd, 0);
    check("t4_idle_empty", bus.Empty, 1);
    read_line(1);
    read_line(0);

    // Same-cycle ack and response, FillStart in WAIT ignored
    bus.FillStart = 1'b1;
    cycle();
    bus.FillStart = 1'b0;
    bus.ReqAck = 1'b1;
    cycle();
    drive_rsp(0, 32'hC0);
    model[0] = 32'hC0;
    cycle();
    bus.RspValid = 1'b0;
    cycle();
    check("t6_idx3", bus.ReqLineIdx, 3);
    drive_rsp(1, 32'hC1);
    model[1] = 32'hC1;
    cycle();
    bus.ReqAck = 1'b0;
    check("t6_wait", bus.ReqValid, 0);
    check("t6_lines2", bus.LinesRcvd, 2);
    bus.FillStart = 1'b1;
    drive_rsp(2, 32'hC2);
    model[2] = 32'hC2;
    cycle();
    bus.FillStart = 1'b0;
    check("t6_fill_in_wait", bus.ReqValid, 0);
    check("t6_lines3", bus.LinesRcvd, 3);
    drive_rsp(3, 32'hC3);
    model[3] = 32'hC3;
    cycle();
    bus.RspValid = 1'b0;
    check("t6_lines4", bus.LinesRcvd, 4);
    check("t6_not_full", bus.Full, 0);
    cycle();
    check("t6_full", bus.Full, 1);
    for (int a = 0; a < 4; a++) read_line(a);
    bus.BatchDone = 1'b1;
    cycle();
    bus.BatchDone = 1'b0;
    check("t6_release", bus.Empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
